if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 23 ++
 rtl/if_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and the memory (slave).
interface if_stage_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  imem_req;
  logic [WORD_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [WORD_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: request FSM, fetch PC and a small buffer of fetched
// {address, instruction} pairs feeding decode, with branch flush and stall.
module if_stage #(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Freeze,
  input  logic                  Branch_taken,
  input  logic [WORD_WIDTH-1:0] Branch_address,
  if_stage_if.master            imem,
  output logic                  valid_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic [WORD_WIDTH-1:0] PC_out
);
  localparam int                    PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                    CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [WORD_WIDTH-1:0] STEP    = WORD_WIDTH'(4);

  // state     | meaning
  // S_IDLE    | no request outstanding; may issue at r_fetch_pc
  // S_FETCH   | request outstanding, result will be buffered
  // S_DISCARD | request outstanding, result dropped (branch hit mid-request)
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD} state_t;

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_fetch_pc;
  logic [WORD_WIDTH-1:0] r_disc_addr;
  logic [WORD_WIDTH-1:0] r_buf_addr [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] r_buf_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_issue;
  logic w_done;
  logic w_push;
  logic w_pop;

  always_comb begin
    w_issue         = rst && (r_state == S_IDLE) && (r_count < DEPTH_C) && !Branch_taken;
    w_done          = (w_issue || (r_state == S_FETCH)) && imem.imem_ready;
    w_push          = w_done && !Branch_taken;
    valid_out       = (r_count != '0);
    w_pop           = valid_out && !Freeze && !Branch_taken;
    imem.imem_req   = w_issue || (r_state != S_IDLE);
    imem.imem_addr  = (r_state == S_DISCARD) ? r_disc_addr : r_fetch_pc;
    instruction_out = valid_out ? r_buf_data[r_rd_ptr] : '0;
    PC_out          = valid_out ? (r_buf_addr[r_rd_ptr] + STEP) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= '0;
      r_disc_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Branch_taken) begin
            r_fetch_pc <= Branch_address;
          end else if (w_issue) begin
            // zero-wait memory completes in the issue cycle and stays in IDLE
            if (imem.imem_ready) r_fetch_pc <= r_fetch_pc + STEP;
            else                 r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem.imem_ready) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= Branch_taken ? Branch_address : (r_fetch_pc + STEP);
          end else if (Branch_taken) begin
            r_state     <= S_DISCARD;
            r_disc_addr <= r_fetch_pc;
            r_fetch_pc  <= Branch_address;
          end
        end
        S_DISCARD: begin
          if (Branch_taken)    r_fetch_pc <= Branch_address;
          if (imem.imem_ready) r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (Branch_taken) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_addr[r_wr_ptr] <= imem.imem_addr;
      r_buf_data[r_wr_ptr] <= imem.imem_rdata;
    end
  end
endmodule
